// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and register constants for the pipeline control blocks.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        ECALL_WAIT = 2'd1,
        DRAIN      = 2'd2,
        HALTED     = 2'd3
    } ctrl_state_e;

    localparam logic [4:0]  REG_X0    = 5'd0;
    localparam logic [4:0]  REG_A7    = 5'd17;
    localparam logic [31:0] HALT_CODE = 32'd10;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of ID-stage hazard inputs and pipeline-register control outputs.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
) ();
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             IF_ID_use_rs1;
    logic             IF_ID_use_rs2;
    logic             IF_ID_is_ecall;
    logic             IF_ID_is_halt;
    logic [4:0]       ID_EX_rd;
    logic             ID_EX_reg_write;
    logic             ID_EX_mem_read;
    logic [4:0]       EX_MEM_rd;
    logic             EX_MEM_reg_write;
    logic             EX_MEM_mem_read;
    logic             ex_mispredict;
    logic             pc_write;
    logic             IF_ID_write;
    logic             ID_EX_bubble;
    logic             IF_ID_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    // No handshake: every field is level-sampled once per clock; controls are
    // combinational responses to the same cycle's hazard inputs.
    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
        input  IF_ID_is_ecall, IF_ID_is_halt,
        input  ID_EX_rd, ID_EX_reg_write, ID_EX_mem_read,
        input  EX_MEM_rd, EX_MEM_reg_write, EX_MEM_mem_read, ex_mispredict,
        output pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
        output halted, stall_cycles
    );

    modport master (
        output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
        output IF_ID_is_ecall, IF_ID_is_halt,
        output ID_EX_rd, ID_EX_reg_write, ID_EX_mem_read,
        output EX_MEM_rd, EX_MEM_reg_write, EX_MEM_mem_read, ex_mispredict,
        input  pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
        input  halted, stall_cycles
    );
endinterface

// File: rtl/hazard_detect_comb.sv
// Pure combinational hazard detection: load-use and ecall stall length.
module hazard_detect_comb
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_reg_write,
    input  logic       id_ex_mem_read,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_reg_write,
    input  logic       ex_mem_mem_read,
    output logic       load_use,
    output logic [1:0] ecall_len
);

    always_comb begin
        load_use  = id_ex_mem_read && (id_ex_rd != REG_X0) &&
                    ((use_rs1 && (rs1 == id_ex_rd)) || (use_rs2 && (rs2 == id_ex_rd)));
        ecall_len = 2'd0;
        // A load into a7 still in EX needs two cycles before MEM/WB can forward it.
        if (id_ex_reg_write && (id_ex_rd == REG_A7) && id_ex_mem_read) begin
            ecall_len = 2'd2;
        end else if (id_ex_reg_write && (id_ex_rd == REG_A7)) begin
            ecall_len = 2'd1;
        end else if (ex_mem_mem_read && ex_mem_reg_write && (ex_mem_rd == REG_A7)) begin
            ecall_len = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/bubble/flush/halt sequencer for the 5-stage core, with a stall-cycle counter.
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_DRAIN = 3,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    hazard_stall_controller_if.slave  hz,
    output ctrl_state_e               state_dbg
);

    localparam int CNT_BITS = $clog2(NUM_DRAIN + 2);

    ctrl_state_e         state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic                load_use;
    logic [1:0]          ecall_len;
    logic                pc_write, if_id_write, id_ex_bubble, if_id_flush;

    hazard_detect_comb u_detect (
        .rs1              (hz.IF_ID_rs1),
        .rs2              (hz.IF_ID_rs2),
        .use_rs1          (hz.IF_ID_use_rs1),
        .use_rs2          (hz.IF_ID_use_rs2),
        .id_ex_rd         (hz.ID_EX_rd),
        .id_ex_reg_write  (hz.ID_EX_reg_write),
        .id_ex_mem_read   (hz.ID_EX_mem_read),
        .ex_mem_rd        (hz.EX_MEM_rd),
        .ex_mem_reg_write (hz.EX_MEM_reg_write),
        .ex_mem_mem_read  (hz.EX_MEM_mem_read),
        .load_use         (load_use),
        .ecall_len        (ecall_len)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.ex_mispredict) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (hz.IF_ID_is_ecall && (ecall_len != 2'd0)) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = CNT_BITS'(ecall_len - 2'd1);
                    if (ecall_len > 2'd1) state_d = ECALL_WAIT;
                end else if (hz.IF_ID_is_ecall && hz.IF_ID_is_halt) begin
                    // The ecall itself moves on to ID/EX; fetch is frozen behind it.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    cnt_d        = CNT_BITS'(NUM_DRAIN - 1);
                    state_d      = DRAIN;
                end
            end
            ECALL_WAIT: begin
                if (hz.ex_mispredict) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = '0;
                    state_d      = RUN;
                end else begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_BITS'(1);
                    if (cnt_q <= CNT_BITS'(1)) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (cnt_q == '0) state_d = HALTED;
                else             cnt_d   = cnt_q - CNT_BITS'(1);
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        endcase

        halted_d       = (state_d == HALTED);
        stall_cycles_d = stall_cycles_q;
        if (id_ex_bubble && !if_id_flush && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            halted_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            halted_q       <= halted_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.IF_ID_write  = if_id_write;
    assign hz.ID_EX_bubble = id_ex_bubble;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.halted       = halted_q;
    assign hz.stall_cycles = stall_cycles_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller with hand-computed expectations.
module tb_hazard_stall_controller;
    import pipeline_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    ctrl_state_e state_dbg;
    int          n_checks;
    int          n_errors;
    int          exp_stall;

    hazard_stall_controller_if #(.CNT_W(32)) hz ();

    hazard_stall_controller #(.NUM_DRAIN(3), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .hz        (hz.slave),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.IF_ID_rs1 = 5'd0;        hz.IF_ID_rs2 = 5'd0;
        hz.IF_ID_use_rs1 = 1'b0;    hz.IF_ID_use_rs2 = 1'b0;
        hz.IF_ID_is_ecall = 1'b0;   hz.IF_ID_is_halt = 1'b0;
        hz.ID_EX_rd = 5'd0;         hz.ID_EX_reg_write = 1'b0;  hz.ID_EX_mem_read = 1'b0;
        hz.EX_MEM_rd = 5'd0;        hz.EX_MEM_reg_write = 1'b0; hz.EX_MEM_mem_read = 1'b0;
        hz.ex_mispredict = 1'b0;
    endtask

    // exp bits: {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush}
    task automatic check_ctrl(input string tag, input logic [3:0] exp);
        #1;
        check_eq(tag, 32'({hz.pc_write, hz.IF_ID_write, hz.ID_EX_bubble, hz.IF_ID_flush}),
                 32'(exp));
    endtask

    task automatic check_regs(input string tag, input ctrl_state_e st, input logic hlt);
        check_eq({tag, ".state"},  32'(state_dbg),       32'(st));
        check_eq({tag, ".halted"}, 32'(hz.halted),       32'(hlt));
        check_eq({tag, ".stalls"}, hz.stall_cycles,      32'(exp_stall));
    endtask

    task automatic id_ex_load(input logic [4:0] rd);
        hz.ID_EX_rd = rd; hz.ID_EX_reg_write = 1'b1; hz.ID_EX_mem_read = 1'b1;
    endtask

    task automatic id_read(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        hz.IF_ID_rs1 = r1; hz.IF_ID_use_rs1 = u1; hz.IF_ID_rs2 = r2; hz.IF_ID_use_rs2 = u2;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = 0;
        reset     = 1'b1;
        idle();
        tick();
        tick();
        check_regs("reset", RUN, 1'b0);
        check_ctrl("reset_ctrl", 4'b1100);
        reset = 1'b0;

        // lw x5 in EX, add x6,x5,x1 in ID: one stall cycle
        idle(); id_ex_load(5'd5); id_read(5'd5, 1'b1, 5'd1, 1'b1);
        check_ctrl("lu_rs1", 4'b0010);
        tick(); exp_stall = 1;
        check_regs("lu_rs1_after", RUN, 1'b0);
        idle(); hz.EX_MEM_rd = 5'd5; hz.EX_MEM_reg_write = 1'b1; hz.EX_MEM_mem_read = 1'b1;
        id_read(5'd5, 1'b1, 5'd1, 1'b1);
        check_ctrl("lu_resolved", 4'b1100);
        tick();
        check_regs("lu_resolved_after", RUN, 1'b0);

        // hazard through rs2 only; then same register but rs2 unused
        idle(); id_ex_load(5'd7); id_read(5'd3, 1'b1, 5'd7, 1'b1);
        check_ctrl("lu_rs2", 4'b0010);
        hz.IF_ID_use_rs2 = 1'b0;
        check_ctrl("lu_rs2_unused", 4'b1100);
        hz.IF_ID_use_rs2 = 1'b1;
        tick(); exp_stall = 2;
        check_regs("lu_rs2_after", RUN, 1'b0);

        // lw x0 in EX with reads of x0: never a hazard
        idle(); id_ex_load(5'd0); id_read(5'd0, 1'b1, 5'd0, 1'b1);
        check_ctrl("x0_no_stall", 4'b1100);
        tick();
        check_regs("x0_after", RUN, 1'b0);

        // lw x17 in EX, ecall in ID: two stall cycles via ECALL_WAIT
        idle(); id_ex_load(5'd17); hz.IF_ID_is_ecall = 1'b1;
        check_ctrl("ecall2_c0", 4'b0010);
        tick(); exp_stall = 3;
        check_regs("ecall2_c0_after", ECALL_WAIT, 1'b0);
        idle(); hz.IF_ID_is_ecall = 1'b1;
        hz.EX_MEM_rd = 5'd17; hz.EX_MEM_reg_write = 1'b1; hz.EX_MEM_mem_read = 1'b1;
        check_ctrl("ecall2_c1", 4'b0010);
        tick(); exp_stall = 4;
        check_regs("ecall2_c1_after", RUN, 1'b0);
        idle(); hz.IF_ID_is_ecall = 1'b1;
        check_ctrl("ecall2_go", 4'b1100);
        tick();
        check_regs("ecall2_go_after", RUN, 1'b0);

        // load of x17 already in EX/MEM: one stall; plain ALU write in EX/MEM: none
        idle(); hz.IF_ID_is_ecall = 1'b1;
        hz.EX_MEM_rd = 5'd17; hz.EX_MEM_reg_write = 1'b1; hz.EX_MEM_mem_read = 1'b1;
        check_ctrl("ecall_exmem_load", 4'b0010);
        tick(); exp_stall = 5;
        check_regs("ecall_exmem_load_after", RUN, 1'b0);
        hz.EX_MEM_mem_read = 1'b0;
        check_ctrl("ecall_exmem_alu", 4'b1100);
        tick();

        // mispredict beats a concurrent load-use
        idle(); id_ex_load(5'd9); id_read(5'd9, 1'b1, 5'd0, 1'b0); hz.ex_mispredict = 1'b1;
        check_ctrl("mp_vs_lu", 4'b1111);
        tick();
        check_regs("mp_vs_lu_after", RUN, 1'b0);

        // mispredict during ECALL_WAIT flushes and returns to RUN
        idle(); id_ex_load(5'd17); hz.IF_ID_is_ecall = 1'b1;
        check_ctrl("mp_ew_enter", 4'b0010);
        tick(); exp_stall = 6;
        check_regs("mp_ew_enter_after", ECALL_WAIT, 1'b0);
        idle(); hz.ex_mispredict = 1'b1;
        check_ctrl("mp_ew", 4'b1111);
        tick();
        check_regs("mp_ew_after", RUN, 1'b0);

        // addi x17 in EX, ecall: one stall, then halting ecall, 3-cycle drain
        idle(); hz.ID_EX_rd = 5'd17; hz.ID_EX_reg_write = 1'b1; hz.IF_ID_is_ecall = 1'b1;
        check_ctrl("halt_stall", 4'b0010);
        tick(); exp_stall = 7;
        check_regs("halt_stall_after", RUN, 1'b0);
        idle(); hz.EX_MEM_rd = 5'd17; hz.EX_MEM_reg_write = 1'b1;
        hz.IF_ID_is_ecall = 1'b1; hz.IF_ID_is_halt = 1'b1;
        check_ctrl("halt_issue", 4'b0000);
        tick();
        check_regs("drain_e1", DRAIN, 1'b0);
        idle(); hz.ex_mispredict = 1'b1;
        check_ctrl("drain_ignores_mp", 4'b0010);
        tick(); exp_stall = 8;
        check_regs("drain_e2", DRAIN, 1'b0);
        tick(); exp_stall = 9;
        check_regs("drain_e3", DRAIN, 1'b0);
        tick(); exp_stall = 10;
        check_regs("halted_e4", HALTED, 1'b1);
        check_ctrl("halted_ctrl", 4'b0010);
        tick(); exp_stall = 11;
        check_regs("halted_stays", HALTED, 1'b1);

        // reset out of HALTED, then reset mid-DRAIN
        reset = 1'b1;
        tick(); exp_stall = 0;
        check_regs("reset_from_halted", RUN, 1'b0);
        reset = 1'b0;
        idle(); hz.IF_ID_is_ecall = 1'b1; hz.IF_ID_is_halt = 1'b1;
        check_ctrl("halt_direct", 4'b0000);
        tick();
        check_regs("drain2_e1", DRAIN, 1'b0);
        idle();
        tick(); exp_stall = 1;
        check_regs("drain2_e2", DRAIN, 1'b0);
        reset = 1'b1;
        tick(); exp_stall = 0;
        check_regs("reset_mid_drain", RUN, 1'b0);
        reset = 1'b0;
        check_ctrl("post_reset_ctrl", 4'b1100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline-control block that drives the stall, bubble, flush and halt side of the data-forwarding path in the 5-stage RISC-V core. Forwarding only covers hazards whose value already exists in EX/MEM or MEM/WB; this block holds IF/ID and the PC and injects ID/EX bubbles until that is true. It sequences multi-cycle ecall stalls and the ecall-halt pipeline drain, and keeps a stall-cycle counter. Sits beside the ID stage; its outputs gate the PC, IF/ID and ID/EX registers.

## Interface
- NUM_DRAIN, 3, cycles spent draining after a halting ecall before `halted` asserts
- CNT_W, 32, width of the stall-cycle counter
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- IF_ID_rs1, IF_ID_rs2  input  5  source registers of the instruction in ID
- IF_ID_use_rs1, IF_ID_use_rs2  input  1  the ID instruction actually reads rs1/rs2
- IF_ID_is_ecall  input  1  the ID instruction is ecall (implicitly reads x17)
- IF_ID_is_halt  input  1  the forwarded x17 value equals 10; valid only when no ecall stall is required
- ID_EX_rd, EX_MEM_rd  input  5  destination registers
- ID_EX_reg_write, ID_EX_mem_read, EX_MEM_reg_write, EX_MEM_mem_read  input  1  control bits of those stages
- ex_mispredict  input  1  branch/jump resolved in EX with a wrong next PC
- pc_write  output  1  PC load enable
- IF_ID_write  output  1  IF/ID load enable
- ID_EX_bubble  output  1  load a NOP into ID/EX
- IF_ID_flush  output  1  load a NOP into IF/ID
- halted  output  1  registered; pipeline drained after a halting ecall
- stall_cycles  output  CNT_W  registered, saturating count of cycles with `ID_EX_bubble` = 1 and no flush

## Operation
- States: RUN, ECALL_WAIT, DRAIN, HALTED.
- Register x0 never causes a hazard. A read of x0 is treated as no read.
- load_use: ID_EX_mem_read && ID_EX_rd != 0 && ((use_rs1 && rs1 == ID_EX_rd) || (use_rs2 && rs2 == ID_EX_rd)).
- ecall stall length, evaluated in RUN:
  - 2 if ID_EX_reg_write && ID_EX_rd == 17 && ID_EX_mem_read
  - else 1 if ID_EX_reg_write && ID_EX_rd == 17
  - else 1 if EX_MEM_mem_read && EX_MEM_reg_write && EX_MEM_rd == 17
  - else 0
- RUN:
  - ex_mispredict: IF_ID_flush = 1, ID_EX_bubble = 1. This has priority over everything else and the state stays RUN.
  - else load_use: pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1, for one cycle.
  - else ecall with stall length N > 0: same stall outputs this cycle. Load cnt = N-1; go to ECALL_WAIT if N-1 > 0, else stay in RUN.
  - else ecall && IF_ID_is_halt: ID_EX_bubble = 0 so the ecall advances; pc_write = 0, IF_ID_write = 0. Load cnt = NUM_DRAIN-1 and go to DRAIN.
  - otherwise all enables are 1 and bubble/flush are 0.
- ECALL_WAIT:
  - Stall outputs asserted and cnt decrements; return to RUN when cnt == 0.
  - ex_mispredict here means flush, and the state goes straight to RUN.
- DRAIN: pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1. cnt decrements; go to HALTED at 0. ex_mispredict is ignored.
- HALTED: same outputs as DRAIN, with halted = 1. Only reset exits.
- stall_cycles increments on any cycle with ID_EX_bubble && !IF_ID_flush and saturates at all-ones.

## Timing
- pc_write, IF_ID_write, ID_EX_bubble and IF_ID_flush are combinational, driven from the state and the current-cycle inputs (Mealy). They have no latency.
- halted, stall_cycles, state and cnt are registered.
- Reset values: state = RUN, cnt = 0, halted = 0, stall_cycles = 0. Combinational outputs take their RUN values from the inputs in the same cycle.
- Reset asserted in any state, including mid-DRAIN or mid-ECALL_WAIT, takes effect at the next edge. Pending stalls are dropped.
- A load-use stall followed by an ecall: after the stall, re-evaluation in RUN sees the producer in EX/MEM and gives N = 1. Total is 2 stall cycles, with no double counting.

## Structure
- Shared package `pipeline_ctrl_pkg`: state enum, REG_X0 = 0, REG_A7 = 17, HALT_CODE = 10.
- Sub-module `hazard_detect_comb` is pure combinational. It produces load_use and the ecall stall length (2 bits). The FSM, counter and output logic live in the top.

## Test plan
- ID_EX lw x5, ID add x6,x5,x1 -> one cycle of pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1; stall_cycles 0 -> 1.
- ID_EX lw x17, ID ecall -> 2 stall cycles, ECALL_WAIT for 1 cycle, then RUN; stall_cycles = 2.
- ID_EX addi x17, ID ecall with is_halt after stall -> 1 stall, then DRAIN for 3 cycles; halted = 1 on the 4th edge after the ecall leaves ID.
- ex_mispredict asserted in the same cycle as load_use, and separately during ECALL_WAIT -> IF_ID_flush = 1, ID_EX_bubble = 1, state RUN, stall_cycles unchanged.
- Reads of x0 with ID_EX lw x0 -> no stall. Also: reset asserted during DRAIN -> next cycle state RUN, halted = 0, stall_cycles = 0.
